fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage_buffer.sv | 53 +++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, types and PC helpers for the fetch stage.
//   RESET_VECTOR - first fetch address after reset
//   NOP_INSTR    - instruction presented to decode when nothing valid is held
//   FETCH_DEPTH  - credits shared by in-flight requests and buffered responses
package fetch_stage_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int unsigned FETCH_DEPTH  = 2;

  typedef logic [31:0] word_t;
  // Holds 0..FETCH_DEPTH
  typedef logic [1:0]  cnt_t;

  // Sequential PC; wraps modulo 2^32
  function automatic word_t pc_next(input word_t pc);
    return pc + 32'd4;
  endfunction

  function automatic word_t align_word(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   IMEM_Req/IMEM_Addr      - request from fetch (master)
//   IMEM_Gnt                - memory accepts the request this cycle
//   IMEM_Rsp_Valid/Rsp_Data - in-order response, at least one cycle after grant
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  IMEM_Req;
  word_t IMEM_Addr;
  logic  IMEM_Gnt;
  logic  IMEM_Rsp_Valid;
  word_t IMEM_Rsp_Data;

  modport master (
    output IMEM_Req, IMEM_Addr,
    input  IMEM_Gnt, IMEM_Rsp_Valid, IMEM_Rsp_Data
  );

  modport slave (
    input  IMEM_Req, IMEM_Addr,
    output IMEM_Gnt, IMEM_Rsp_Valid, IMEM_Rsp_Data
  );
endinterface

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: 2-entry response FIFO between instruction memory and decode.
//   i_clk/i_rst - clock, synchronous active-high reset
//   i_clear     - drop all entries (redirect)
//   i_push      - write i_data at tail
//   i_pop       - remove head (may coincide with push)
//   o_count     - number of held entries
//   o_head      - oldest entry
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_clear,
  input  logic  i_push,
  input  logic  i_pop,
  input  word_t i_data,
  output cnt_t  o_count,
  output word_t o_head
);

  word_t r_mem [FETCH_DEPTH];
  logic  r_wr_ptr;
  logic  r_rd_ptr;
  cnt_t  r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
    !(i_push && !i_pop && r_count == cnt_t'(FETCH_DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch feeding the decode register.
//   CLK, RST            - clock, synchronous active-high reset
//   Stall_D             - hold decode outputs
//   Redirect_E          - taken branch/jump from execute (overrides stall)
//   PC_Target_E         - redirect target (low two bits ignored)
//   imem                - instruction memory bus (master side)
//   Instr_D/PC_D/PC4_D  - decode instruction, its PC, PC+4
//   Valid_D             - Instr_D is a real fetched instruction
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          Stall_D,
  input  logic          Redirect_E,
  input  word_t         PC_Target_E,
  fetch_stage_if.master imem,
  output word_t         Instr_D,
  output word_t         PC_D,
  output word_t         PC4_D,
  output logic          Valid_D
);

  word_t r_fetch_pc;
  word_t r_head_pc;
  cnt_t  r_outstanding;
  cnt_t  r_discard;
  word_t r_instr;
  word_t r_pc;
  word_t r_pc4;
  logic  r_valid;

  cnt_t       w_buf_count;
  word_t      w_buf_head;
  logic [2:0] w_credits_used;
  logic       w_req;
  logic       w_issue;
  logic       w_rsp_drop;
  logic       w_rsp_owed;
  logic       w_push;
  logic       w_pop;
  cnt_t       w_discard_redirect;

  always_comb begin
    w_credits_used = {1'b0, r_outstanding} + {1'b0, w_buf_count};
    w_req          = !RST && !Redirect_E && (r_discard == '0)
                     && (w_credits_used < 3'(FETCH_DEPTH));
    w_issue        = w_req && imem.IMEM_Gnt;
    w_rsp_drop     = imem.IMEM_Rsp_Valid && (r_discard != '0);
    w_rsp_owed     = imem.IMEM_Rsp_Valid && ((r_discard != '0) || (r_outstanding != '0));
    // A response landing with the redirect is stale and never reaches the buffer
    w_push         = imem.IMEM_Rsp_Valid && (r_discard == '0) && (r_outstanding != '0)
                     && !Redirect_E;
    w_pop          = !Redirect_E && !Stall_D && (w_buf_count != '0);
    // Everything still owed becomes discard; one arriving now is already consumed
    w_discard_redirect = r_discard + r_outstanding - cnt_t'(w_rsp_owed);
  end

  assign imem.IMEM_Req  = w_req;
  assign imem.IMEM_Addr = RST ? RESET_VECTOR : r_fetch_pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_head_pc     <= RESET_VECTOR;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_instr       <= NOP_INSTR;
      r_pc          <= RESET_VECTOR;
      r_pc4         <= pc_next(RESET_VECTOR);
      r_valid       <= 1'b0;
    end else if (Redirect_E) begin
      r_fetch_pc    <= align_word(PC_Target_E);
      r_head_pc     <= align_word(PC_Target_E);
      r_outstanding <= '0;
      r_discard     <= w_discard_redirect;
      r_instr       <= NOP_INSTR;
      r_valid       <= 1'b0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= pc_next(r_fetch_pc);
      end
      case ({w_issue, w_push})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_rsp_drop) begin
        r_discard <= r_discard - 2'd1;
      end
      if (!Stall_D) begin
        if (w_pop) begin
          r_instr   <= w_buf_head;
          r_pc      <= r_head_pc;
          r_pc4     <= pc_next(r_head_pc);
          r_valid   <= 1'b1;
          r_head_pc <= pc_next(r_head_pc);
        end else begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      end
    end
  end

  fetch_buffer u_buffer (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clear (Redirect_E),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (imem.IMEM_Rsp_Data),
    .o_count (w_buf_count),
    .o_head  (w_buf_head)
  );

  assign Instr_D = r_instr;
  assign PC_D    = r_pc;
  assign PC4_D   = r_pc4;
  assign Valid_D = r_valid;

endmodule
